// File: rtl/rega_zonas.sv
// rtl/rega_zonas.sv - four-zone irrigation sequencer: select, water, settle, advance, low-reservoir alarm
module rega_zonas #(
    parameter int T_REGA  = 8,
    parameter int T_PAUSA = 2
) (
    input  logic       Clk,
    input  logic       Rstn,
    input  logic       En,
    input  logic [1:0] Zona,
    input  logic [3:0] Seco,
    input  logic       Nivel,
    output logic [3:0] Valv,
    output logic       Bomba,
    output logic       Adv,
    output logic       Alarme,
    output logic       Ocupado
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_REGA,
        S_PAUSA,
        S_ADV,
        S_ALARM
    } state_t;

    localparam logic [7:0] REGA_LOAD  = 8'(T_REGA - 1);
    localparam logic [7:0] PAUSA_LOAD = 8'(T_PAUSA - 1);
    // Reservoir must read OK for this many extra cycles after the first good sample.
    localparam logic [7:0] ALM_LOAD   = 8'd3;

    state_t     state, state_nx;
    logic [1:0] zone, zone_nx;
    logic [7:0] dur_cnt, dur_nx;
    logic [7:0] alm_cnt, alm_nx;
    logic [3:0] valv_nx;
    logic       bomba_nx, adv_nx, alarme_nx, ocupado_nx;

    always_comb begin
        state_nx = state;
        zone_nx  = zone;
        dur_nx   = dur_cnt;
        alm_nx   = alm_cnt;
        case (state)
            S_IDLE: begin
                if (En) state_nx = S_SEL;
            end
            S_SEL: begin
                zone_nx = Zona;
                if (!Nivel) begin
                    state_nx = S_ALARM;
                    alm_nx   = ALM_LOAD;
                end else if (Seco[Zona]) begin
                    state_nx = S_REGA;
                    dur_nx   = REGA_LOAD;
                end else begin
                    state_nx = S_ADV;
                end
            end
            S_REGA: begin
                // Empty reservoir outranks both the soil going wet and normal expiry.
                if (!Nivel) begin
                    state_nx = S_ALARM;
                    alm_nx   = ALM_LOAD;
                end else if (!Seco[zone] || dur_cnt == 8'd0) begin
                    state_nx = S_PAUSA;
                    dur_nx   = PAUSA_LOAD;
                end else begin
                    dur_nx = dur_cnt - 8'd1;
                end
            end
            S_PAUSA: begin
                if (dur_cnt == 8'd0) state_nx = S_ADV;
                else dur_nx = dur_cnt - 8'd1;
            end
            S_ADV: begin
                state_nx = En ? S_SEL : S_IDLE;
            end
            S_ALARM: begin
                if (!Nivel) alm_nx = ALM_LOAD;
                else if (alm_cnt == 8'd0) state_nx = S_IDLE;
                else alm_nx = alm_cnt - 8'd1;
            end
            default: state_nx = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies line up with the state.
        valv_nx    = (state_nx == S_REGA) ? (4'b0001 << zone_nx) : 4'b0000;
        bomba_nx   = (state_nx == S_REGA);
        adv_nx     = (state_nx == S_ADV);
        alarme_nx  = (state_nx == S_ALARM);
        ocupado_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state   <= S_IDLE;
            zone    <= 2'd0;
            dur_cnt <= 8'd0;
            alm_cnt <= 8'd0;
            Valv    <= 4'b0000;
            Bomba   <= 1'b0;
            Adv     <= 1'b0;
            Alarme  <= 1'b0;
            Ocupado <= 1'b0;
        end else begin
            state   <= state_nx;
            zone    <= zone_nx;
            dur_cnt <= dur_nx;
            alm_cnt <= alm_nx;
            Valv    <= valv_nx;
            Bomba   <= bomba_nx;
            Adv     <= adv_nx;
            Alarme  <= alarme_nx;
            Ocupado <= ocupado_nx;
        end
    end

endmodule

// File: tb/tb_rega_zonas.sv
// tb/tb_rega_zonas.sv - scoreboard bench for rega_zonas with an external mod-4 down-counter on Adv
module tb_rega_zonas;

    logic       Clk = 1'b0;
    logic       Rstn;
    logic       En;
    logic [1:0] Zona;
    logic [3:0] Seco;
    logic       Nivel;
    logic [3:0] Valv;
    logic       Bomba, Adv, Alarme, Ocupado;
    logic [7:0] out_vec;

    always #5 Clk = ~Clk;

    rega_zonas #(.T_REGA(8), .T_PAUSA(2)) dut (
        .Clk(Clk), .Rstn(Rstn), .En(En), .Zona(Zona), .Seco(Seco), .Nivel(Nivel),
        .Valv(Valv), .Bomba(Bomba), .Adv(Adv), .Alarme(Alarme), .Ocupado(Ocupado)
    );

    assign out_vec = {Valv, Bomba, Adv, Alarme, Ocupado};

    // Zone counter: counts down on each Adv pulse, loadable from the bench.
    logic       load_req = 1'b0;
    logic [1:0] load_val = 2'd0;
    always @(posedge Clk) begin
        if (load_req) Zona <= load_val;
        else if (Adv) Zona <= Zona - 2'd1;
    end

    typedef struct { logic [7:0] v; int due; int tag; } exp_t;
    typedef struct { logic [3:0] seco; logic [1:0] zone; int water; } visit_t;

    localparam logic [7:0] E_IDLE  = 8'b0000_0000;
    localparam logic [7:0] E_BUSY  = 8'b0000_0001;
    localparam logic [7:0] E_ADV   = 8'b0000_0101;
    localparam logic [7:0] E_ALARM = 8'b0000_0011;

    exp_t   sb[$];
    exp_t   mon_x;
    visit_t visits[13];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     tag_ctr = 0;

    function automatic logic [7:0] e_rega(input logic [1:0] z);
        logic [3:0] oh;
        oh = 4'b0001 << z;
        return {oh, 1'b1, 1'b0, 1'b0, 1'b1};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs for the next edge and queue the outputs expected right after it.
    task automatic step(input logic en, input logic [3:0] seco, input logic nivel, input logic [7:0] e);
        En    = en;
        Seco  = seco;
        Nivel = nivel;
        sb.push_back('{v: e, due: cyc + 1, tag: tag_ctr});
        tag_ctr++;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge Clk);
            cyc++;
            #2;
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_x = sb.pop_front();
                n_cmp++;
                if (out_vec !== mon_x.v) begin
                    n_bad++;
                    $display("FAIL step%0d {valv,bomba,adv,alarme,ocupado}: got %b expected %b",
                             mon_x.tag, out_vec, mon_x.v);
                end
            end
        end
    end

    initial begin
        visits[0]  = '{4'b1111, 2'd3, 8};
        visits[1]  = '{4'b1111, 2'd2, 8};
        visits[2]  = '{4'b1111, 2'd1, 8};
        visits[3]  = '{4'b1111, 2'd0, 8};
        visits[4]  = '{4'b1111, 2'd3, 8};
        visits[5]  = '{4'b0000, 2'd2, 0};
        visits[6]  = '{4'b0000, 2'd1, 0};
        visits[7]  = '{4'b0000, 2'd0, 0};
        visits[8]  = '{4'b0000, 2'd3, 0};
        visits[9]  = '{4'b0101, 2'd2, 8};
        visits[10] = '{4'b0101, 2'd1, 0};
        visits[11] = '{4'b0101, 2'd0, 8};
        visits[12] = '{4'b0101, 2'd3, 0};

        Rstn = 1'b0; En = 1'b0; Seco = 4'b0000; Nivel = 1'b1;
        load_val = 2'd3; load_req = 1'b1;
        @(posedge Clk); #1;
        load_req = 1'b0;
        chk("reset_outputs", int'(out_vec), 0);
        @(posedge Clk); #1;
        chk("reset_hold_outputs", int'(out_vec), 0);
        #3 Rstn = 1'b1;

        // Full sweep, dry-soil skips and a mixed mask, all with En=1 and water available.
        for (int i = 0; i < 13; i++) begin
            step(1'b1, visits[i].seco, 1'b1, E_BUSY);
            for (int k = 0; k < visits[i].water; k++)
                step(1'b1, visits[i].seco, 1'b1, e_rega(visits[i].zone));
            if (visits[i].water > 0) begin
                step(1'b1, visits[i].seco, 1'b1, E_BUSY);
                step(1'b1, visits[i].seco, 1'b1, E_BUSY);
            end
            step(1'b1, visits[i].seco, 1'b1, E_ADV);
        end
        step(1'b0, 4'b0000, 1'b1, E_IDLE);

        // Reservoir empties on REGA cycle 3 of zone 2; recovery interrupted once.
        step(1'b1, 4'b0100, 1'b1, E_BUSY);
        for (int k = 0; k < 3; k++) step(1'b0, 4'b0100, 1'b1, e_rega(2'd2));
        step(1'b0, 4'b0100, 1'b0, E_ALARM);
        for (int k = 0; k < 3; k++) step(1'b0, 4'b0100, 1'b1, E_ALARM);
        step(1'b0, 4'b0100, 1'b0, E_ALARM);
        for (int k = 0; k < 3; k++) step(1'b0, 4'b0100, 1'b1, E_ALARM);
        step(1'b0, 4'b0100, 1'b1, E_IDLE);
        step(1'b0, 4'b0100, 1'b1, E_IDLE);

        // Zone 2 skipped, then zone 1 goes wet on REGA cycle 5.
        step(1'b1, 4'b0000, 1'b1, E_BUSY);
        step(1'b1, 4'b0000, 1'b1, E_ADV);
        step(1'b1, 4'b0010, 1'b1, E_BUSY);
        for (int k = 0; k < 5; k++) step(1'b1, 4'b0010, 1'b1, e_rega(2'd1));
        step(1'b1, 4'b0000, 1'b1, E_BUSY);
        step(1'b1, 4'b0000, 1'b1, E_BUSY);
        step(1'b1, 4'b0000, 1'b1, E_ADV);
        step(1'b0, 4'b0000, 1'b1, E_IDLE);

        // En drops during zone 0 watering: the zone still completes.
        step(1'b1, 4'b0001, 1'b1, E_BUSY);
        for (int k = 0; k < 8; k++) step(1'b0, 4'b0001, 1'b1, e_rega(2'd0));
        step(1'b0, 4'b0001, 1'b1, E_BUSY);
        step(1'b0, 4'b0001, 1'b1, E_BUSY);
        step(1'b0, 4'b0001, 1'b1, E_ADV);
        step(1'b0, 4'b0001, 1'b1, E_IDLE);
        step(1'b0, 4'b0001, 1'b1, E_IDLE);

        // Asynchronous reset in the middle of zone 3 watering.
        step(1'b1, 4'b1000, 1'b1, E_BUSY);
        for (int k = 0; k < 3; k++) step(1'b1, 4'b1000, 1'b1, e_rega(2'd3));
        #3 Rstn = 1'b0;
        #1;
        chk("async_rst_valv", int'(Valv), 0);
        chk("async_rst_bomba", int'(Bomba), 0);
        chk("async_rst_adv", int'(Adv), 0);
        chk("async_rst_alarme", int'(Alarme), 0);
        chk("async_rst_ocupado", int'(Ocupado), 0);
        En = 1'b1; Seco = 4'b0010;
        load_val = 2'd1; load_req = 1'b1;
        @(posedge Clk); #1;
        load_req = 1'b0;
        chk("rst_held_outputs", int'(out_vec), 0);
        #3 Rstn = 1'b1;
        step(1'b1, 4'b0010, 1'b1, E_BUSY);
        for (int k = 0; k < 8; k++) step(1'b1, 4'b0010, 1'b1, e_rega(2'd1));
        step(1'b1, 4'b0010, 1'b1, E_BUSY);
        step(1'b1, 4'b0010, 1'b1, E_BUSY);
        step(1'b1, 4'b0010, 1'b1, E_ADV);
        step(1'b0, 4'b0010, 1'b1, E_IDLE);

        repeat (2) @(posedge Clk);
        #3;
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
